// File: rtl/alu_issue_stage.sv
// Decodes an RV32I instruction plus register/PC data into ALU op and operands, held in a 2-entry skid buffer.
// Latency 1 cycle; in_ready is the registered inverse of skid occupancy, so out_ready never reaches it combinationally.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                           OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLTU = 4'd6, OP_SLL = 4'd7,
                           OP_SRL = 4'd8, OP_SRA = 4'd9, OP_PASS_B = 4'd10;

    localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OPIMM = 7'b0010011, OPC_LUI = 7'b0110111,
                           OPC_AUIPC = 7'b0010111, OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011,
                           OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef struct packed {
        logic [3:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } payload_t;

    payload_t dec;
    payload_t main_q, main_d, skid_q, skid_d;
    logic     main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic     illegal, writes_rd;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] i_imm, s_imm, u_imm, shamt;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign i_imm  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign s_imm  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign u_imm  = {in_instr[31:12], 12'b0};
    assign shamt  = {27'b0, in_instr[24:20]};

    always_comb begin
        dec       = '0;
        dec.rd    = in_instr[11:7];
        dec.pc    = in_pc;
        illegal   = 1'b0;
        writes_rd = 1'b0;
        unique case (opcode)
            OPC_OP, OPC_OPIMM: begin
                writes_rd = 1'b1;
                dec.a     = in_rs1_data;
                dec.b     = (opcode == OPC_OP) ? in_rs2_data : i_imm;
                case (funct3)
                    3'b000:  dec.op = (opcode == OPC_OP && funct7 == F7_ALT) ? OP_SUB : OP_ADD;
                    3'b001:  dec.op = OP_SLL;
                    3'b010:  dec.op = OP_SLT;
                    3'b011:  dec.op = OP_SLTU;
                    3'b100:  dec.op = OP_XOR;
                    3'b101:  dec.op = (funct7 == F7_ALT) ? OP_SRA : OP_SRL;
                    3'b110:  dec.op = OP_OR;
                    default: dec.op = OP_AND;
                endcase
                if (opcode == OPC_OP) begin
                    if (!(funct7 == 7'b0 || (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))))
                        illegal = 1'b1;
                end else if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // Immediate shifts carry the shift amount, not the sign-extended imm.
                    dec.b = shamt;
                    if (funct7 != 7'b0 && !(funct3 == 3'b101 && funct7 == F7_ALT))
                        illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                writes_rd = 1'b1;
                dec.op    = OP_PASS_B;
                dec.b     = u_imm;
            end
            OPC_AUIPC: begin
                writes_rd = 1'b1;
                dec.a     = in_pc;
                dec.b     = u_imm;
            end
            OPC_LOAD: begin
                writes_rd = 1'b1;
                dec.a     = in_rs1_data;
                dec.b     = i_imm;
            end
            OPC_STORE: begin
                dec.a = in_rs1_data;
                dec.b = s_imm;
            end
            OPC_JAL, OPC_JALR: begin
                writes_rd = 1'b1;
                dec.a     = in_pc;
                dec.b     = 32'd4;
            end
            OPC_BRANCH: begin
                dec.a = in_rs1_data;
                dec.b = in_rs2_data;
                case (funct3[2:1])
                    2'b00:   dec.op = OP_SUB;
                    2'b10:   dec.op = OP_SLT;
                    2'b11:   dec.op = OP_SLTU;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            dec.op = OP_ADD;
            dec.a  = '0;
            dec.b  = '0;
        end
        dec.illegal = illegal;
        dec.rd_we   = writes_rd && (dec.rd != 5'd0) && !illegal;
    end

    logic in_xfer, out_xfer;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = main_vld_q && out_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || out_xfer) begin
            // Skid holds the older entry, so it refills main before any new input.
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (in_xfer) begin
                main_d     = dec;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_d     = dec;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign in_ready    = !skid_vld_q;
    assign out_valid   = main_vld_q;
    assign alu_op      = main_q.op;
    assign alu_a       = main_q.a;
    assign alu_b       = main_q.b;
    assign out_rd      = main_q.rd;
    assign out_rd_we   = main_q.rd_we;
    assign out_illegal = main_q.illegal;
    assign out_pc      = main_q.pc;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: occupancy/queue reference model checked every cycle plus literal spot checks.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, out_pc;
    logic [4:0]  out_rd;
    logic        out_rd_we, out_illegal;

    int total = 0;
    int bad   = 0;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_illegal(out_illegal), .out_pc(out_pc)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] r1, input logic [31:0] r2);
        exp_t       e;
        logic [3:0] rtab [8];
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       wr;
        rtab = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        e.op = 4'd0; e.a = 32'd0; e.b = 32'd0; e.ill = 1'b0;
        e.rd = ins[11:7]; e.pc = pc;
        wr = (opc == 7'h33) || (opc == 7'h13) || (opc == 7'h37) || (opc == 7'h17) ||
             (opc == 7'h03) || (opc == 7'h6F) || (opc == 7'h67);
        if (opc == 7'h33) begin
            e.a = r1; e.b = r2;
            if (f7 == 7'h00) e.op = rtab[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) e.op = 4'd1;
            else if (f7 == 7'h20 && f3 == 3'd5) e.op = 4'd9;
            else e.ill = 1'b1;
        end else if (opc == 7'h13) begin
            e.a = r1; e.op = rtab[f3];
            e.b = {{20{ins[31]}}, ins[31:20]};
            if (f3 == 3'd1) begin
                e.b = 32'(ins[24:20]);
                if (f7 != 7'h00) e.ill = 1'b1;
            end else if (f3 == 3'd5) begin
                e.b = 32'(ins[24:20]);
                if (f7 == 7'h20) e.op = 4'd9;
                else if (f7 != 7'h00) e.ill = 1'b1;
            end
        end else if (opc == 7'h37) begin
            e.op = 4'd10; e.b = ins & 32'hFFFFF000;
        end else if (opc == 7'h17) begin
            e.a = pc; e.b = ins & 32'hFFFFF000;
        end else if (opc == 7'h03) begin
            e.a = r1; e.b = {{20{ins[31]}}, ins[31:20]};
        end else if (opc == 7'h23) begin
            e.a = r1; e.b = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        end else if (opc == 7'h6F || opc == 7'h67) begin
            e.a = pc; e.b = 32'd4;
        end else if (opc == 7'h63) begin
            e.a = r1; e.b = r2;
            if (f3 <= 3'd1) e.op = 4'd1;
            else if (f3 == 3'd4 || f3 == 3'd5) e.op = 4'd5;
            else if (f3 >= 3'd6) e.op = 4'd6;
            else e.ill = 1'b1;
        end else begin
            e.ill = 1'b1;
        end
        if (e.ill) begin
            e.op = 4'd0; e.a = 32'd0; e.b = 32'd0;
        end
        e.we = wr && (e.rd != 5'd0) && !e.ill;
        return e;
    endfunction

    // Reference: an ordered queue of in-flight entries; occupancy alone defines valid/ready.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_alu_op", 32'(alu_op), 32'd0);
            chk("rst_alu_a", alu_a, 32'd0);
            chk("rst_alu_b", alu_b, 32'd0);
            chk("rst_out_pc", out_pc, 32'd0);
        end else begin
            chk("model_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("model_in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (out_valid && q.size() > 0) begin
                chk("model_alu_op", 32'(alu_op), 32'(q[0].op));
                chk("model_alu_a", alu_a, q[0].a);
                chk("model_alu_b", alu_b, q[0].b);
                chk("model_rd", 32'(out_rd), 32'(q[0].rd));
                chk("model_rd_we", 32'(out_rd_we), 32'(q[0].we));
                chk("model_illegal", 32'(out_illegal), 32'(q[0].ill));
                chk("model_pc", out_pc, q[0].pc);
            end
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (flush) q.delete();
            else if (in_valid && in_ready)
                q.push_back(ref_decode(in_instr, in_pc, in_rs1_data, in_rs2_data));
        end
    end

    // Called just after a posedge; returns just after the posedge on which the transfer happened.
    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        int n = 0;
        in_valid = 1'b1; in_instr = ins; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("drive_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic lit(input string n, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic we, input logic ill);
        chk({n, "_valid"}, 32'(out_valid), 32'd1);
        chk({n, "_op"}, 32'(alu_op), 32'(op));
        chk({n, "_a"}, alu_a, a);
        chk({n, "_b"}, alu_b, b);
        chk({n, "_rd"}, 32'(out_rd), 32'(rd));
        chk({n, "_we"}, 32'(out_rd_we), 32'(we));
        chk({n, "_ill"}, 32'(out_illegal), 32'(ill));
    endtask

    logic [31:0] tbl [13] = '{
        32'h00A00093, 32'hFFF00113, 32'h00001197, 32'h008000EF, 32'h00008067,
        32'h00412083, 32'h00112223, 32'h00B50463, 32'h00B57463, 32'h00B51533,
        32'h02B50533, 32'h0205D513, 32'h00B56533
    };

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h40B50533; in_pc = 32'h100;
        in_rs1_data = 32'd7; in_rs2_data = 32'd9;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        lit("sub", 4'd1, 32'd7, 32'd9, 5'd10, 1'b1, 1'b0);

        @(posedge clk); #1;
        drive(32'h4041D193, 32'h104, 32'h80000000, 32'd0);
        @(negedge clk);
        lit("srai", 4'd9, 32'h80000000, 32'd4, 5'd3, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(32'h12345037, 32'h108, 32'h1, 32'h2);
        @(negedge clk);
        lit("lui_x0", 4'd10, 32'd0, 32'h12345000, 5'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(32'hFFFFFFFF, 32'h10C, 32'h55, 32'h66);
        @(negedge clk);
        lit("all_ones", 4'd0, 32'd0, 32'd0, 5'd31, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(32'h00002063, 32'h110, 32'h55, 32'h66);
        @(negedge clk);
        lit("br_f3_010", 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);

        // Table sweep with alternating backpressure; the queue model checks each entry.
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            out_ready = i[0];
            drive(tbl[i], 32'h200 + 32'(i * 4), 32'h1000 + 32'(i), 32'hF0 - 32'(i));
        end
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: both entries fill, then drain in order.
        out_ready = 1'b0;
        drive(32'h00A00093, 32'h300, 32'd0, 32'd0);
        drive(32'h00B50533, 32'h304, 32'd3, 32'd4);
        @(negedge clk);
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        chk("bp_head_pc", out_pc, 32'h300);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_first_out_pc", out_pc, 32'h300);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_in_ready_after_drain", 32'(in_ready), 32'd1);
        chk("bp_second_out_pc", out_pc, 32'h304);
        lit("bp_add", 4'd0, 32'd3, 32'd4, 5'd10, 1'b1, 1'b0);
        @(posedge clk); #1;

        // Flush with both entries full and an input offered.
        out_ready = 1'b0;
        drive(32'h00A00093, 32'h400, 32'd0, 32'd0);
        drive(32'h00A00113, 32'h404, 32'd0, 32'd0);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00100193; in_pc = 32'h408;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);

        // Flush while an input transfer is accepted: that input is discarded too.
        @(posedge clk); #1;
        drive(32'h00A00093, 32'h500, 32'd0, 32'd0);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00100193; in_pc = 32'h504;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("flush_no_reappear", 32'(out_valid), 32'd0);
        end

        // Reset mid-stream drops entries immediately.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(32'h00A00093, 32'h600, 32'd0, 32'd0);
        drive(32'h00A00113, 32'h604, 32'd0, 32'd0);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1; out_ready = 1'b1;
        drive(32'h00000297, 32'h700, 32'd0, 32'd0);
        @(negedge clk);
        lit("auipc_after_rst", 4'd0, 32'h700, 32'd0, 5'd5, 1'b1, 1'b0);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        chk("global_timeout", 32'd0, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
